// File: rtl/y86_logic_pkg.sv
// y86_logic_pkg: shared definitions for the Y86 pipelined logic unit.
// Holds the logic-op encoding, the condition-code bit positions and a
// helper that assembles the {ZF, SF, OF} vector.
package y86_logic_pkg;

  typedef enum logic [1:0] {
    LOP_AND  = 2'd0,
    LOP_OR   = 2'd1,
    LOP_XOR  = 2'd2,
    LOP_ANDN = 2'd3
  } logic_op_t;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Logic ops never overflow, so OF is always driven low here.
  function automatic logic [2:0] pack_cc(input logic zf, input logic sf);
    logic [2:0] cc;
    cc        = 3'b000;
    cc[CC_ZF] = zf;
    cc[CC_SF] = sf;
    cc[CC_OF] = 1'b0;
    return cc;
  endfunction

endpackage

// File: rtl/logic_lane.sv
// logic_lane: combinational op select for one LANE_W-bit slice of the
// operands. The top level tiles WIDTH/LANE_W of these in front of stage 0.
module logic_lane
  import y86_logic_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic_op_t         op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);

  // Select the bitwise function for this lane.
  always_comb begin
    y = {LANE_W{1'b0}};
    case (op)
      LOP_AND:  y = a & b;
      LOP_OR:   y = a | b;
      LOP_XOR:  y = a ^ b;
      LOP_ANDN: y = a & ~b;
      default:  y = {LANE_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// pipelined_logic_unit: STAGES-deep bitwise logic pipeline with a
// valid/ready handshake and Y86 condition codes.
// Optional feature macro: PIPELINED_LOGIC_UNIT_CC_EN builds the flag logic
// and flag register; without it out_cc is tied to 3'b000.
// WIDTH must be a multiple of LANE_W and STAGES must lie in 1..4.
module pipelined_logic_unit
  import y86_logic_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int LANE_W = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_cc
);

  localparam int LANES = WIDTH / LANE_W;

  logic_op_t        op_s;
  logic [WIDTH-1:0] lane_result_s;
  logic             accept_s;

  logic [STAGES-1:0] valid_r;
  logic [WIDTH-1:0]  data_r [STAGES];

  logic [STAGES-1:0] load_s;
  logic [STAGES-1:0] prev_valid_s;
  logic [WIDTH-1:0]  prev_data_s [STAGES];

  assign op_s = logic_op_t'(in_op);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic_lane #(.LANE_W(LANE_W)) u_lane (
      .op (op_s),
      .a  (in_a[i*LANE_W +: LANE_W]),
      .b  (in_b[i*LANE_W +: LANE_W]),
      .y  (lane_result_s[i*LANE_W +: LANE_W])
    );
  end

  // Stage k may load when the consumer drains or any stage from k onward has
  // a hole, which is exactly "empty or the next stage loads" unrolled.
  always_comb begin : load_comb
    logic hole_s;
    hole_s = 1'b0;
    load_s = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      hole_s = 1'b0;
      for (int j = k; j < STAGES; j++) begin
        hole_s = hole_s | ~valid_r[j];
      end
      load_s[k] = hole_s | out_ready;
    end
  end

  assign in_ready = load_s[0] & ~rst;
  assign accept_s = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign prev_valid_s[k] = accept_s;
      assign prev_data_s[k]  = lane_result_s;
    end else begin : g_rest
      assign prev_valid_s[k] = valid_r[k-1];
      assign prev_data_s[k]  = data_r[k-1];
    end
  end

  // Stage registers: valid bits follow the load chain; data only moves with
  // a real beat so a drained stage keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= prev_valid_s[k];
          if (prev_valid_s[k]) begin
            data_r[k] <= prev_data_s[k];
          end else begin
            data_r[k] <= data_r[k];
          end
        end else begin
          valid_r[k] <= valid_r[k];
          data_r[k]  <= data_r[k];
        end
      end
    end
  end

  assign out_valid  = valid_r[STAGES-1];
  assign out_result = data_r[STAGES-1];

`ifdef PIPELINED_LOGIC_UNIT_CC_EN
  logic [2:0] cc_next_s;
  logic [2:0] cc_r;

  // Flags are derived from whatever is about to enter the last stage.
  always_comb begin
    cc_next_s = pack_cc(prev_data_s[STAGES-1] == {WIDTH{1'b0}},
                        prev_data_s[STAGES-1][WIDTH-1]);
  end

  // Flag register travels in lock-step with the last data stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_r <= 3'b000;
    end else if (load_s[STAGES-1] && prev_valid_s[STAGES-1]) begin
      cc_r <= cc_next_s;
    end else begin
      cc_r <= cc_r;
    end
  end

  assign out_cc = cc_r;
`else
  assign out_cc = 3'b000;
`endif

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// tb_pipelined_logic_unit: scoreboard bench. The driver pushes the expected
// beat when a handshake is seen; an independent monitor pops and compares
// whenever the unit presents an accepted output.
module tb_pipelined_logic_unit;

  localparam int WIDTH  = 64;
  localparam int LANE_W = 8;
  localparam int STAGES = 2;
`ifdef PIPELINED_LOGIC_UNIT_CC_EN
  localparam bit CC_ON = 1'b1;
`else
  localparam bit CC_ON = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [2:0]       cc;
    int               cyc;
    bit               lat;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_cc;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  pipelined_logic_unit #(.WIDTH(WIDTH), .LANE_W(LANE_W), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cc     (out_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] ref_res(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  function automatic logic [2:0] ref_cc(input logic [WIDTH-1:0] r);
    if (!CC_ON) return 3'b000;
    return {(r == '0), r[WIDTH-1], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // One cycle of stimulus: drive in the low phase, then note a handshake.
  task automatic step(input bit r, input bit v, input logic [1:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] eres, input logic [2:0] ecc,
                      input bit ordy, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      e.res = eres; e.cc = ecc; e.cyc = cyc; e.lat = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic rnd_step(input bit v, input bit ordy, output bit acc);
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b, r;
    op = 2'($urandom_range(0, 3));
    a  = {$urandom(), $urandom()};
    b  = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) b = a;
    r = ref_res(op, a, b);
    step(1'b0, v, op, a, b, r, ref_cc(r), ordy, 1'b0, acc);
  endtask

  // Monitor: compares every output transfer and checks stalled beats hold.
  initial begin : monitor
    bit               stalled;
    logic [WIDTH-1:0] held_res;
    logic [2:0]       held_cc;
    exp_t             e;
    stalled = 1'b0;
    held_res = '0;
    held_cc = 3'b000;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", WIDTH'(out_valid), WIDTH'(1));
          chk("stall_result", out_result, held_res);
          chk("stall_cc", WIDTH'(out_cc), WIDTH'(held_cc));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_output: got %h expected none (cycle %0d)", out_result, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("result", out_result, e.res);
            chk("cc", WIDTH'(out_cc), WIDTH'(e.cc));
            if (e.lat) chk("latency", WIDTH'(cyc - e.cyc), WIDTH'(STAGES));
          end
        end
        stalled  = out_valid && !out_ready;
        held_res = out_result;
        held_cc  = out_cc;
      end
    end
  end

  initial begin : stimulus
    bit               acc;
    int               got;
    logic [1:0]       bp_op [6];
    logic [WIDTH-1:0] bp_a  [6];
    logic [WIDTH-1:0] bp_b  [6];
    logic [WIDTH-1:0] r;

    rst = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_a = '1; in_b = '1; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'd0, '1, '1, '0, 3'b000, 1'b1, 1'b0, acc);
      chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
      chk("rst_out_result", out_result, WIDTH'(0));
      chk("rst_out_cc", WIDTH'(out_cc), WIDTH'(0));
      chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(0));
    end

    // Directed ops from an empty pipe, consumer always ready.
    step(1'b0, 1'b1, 2'd0, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF,
         64'h0, CC_ON ? 3'b100 : 3'b000, 1'b1, 1'b1, acc);
    chk("first_accept_after_rst", WIDTH'(acc), WIDTH'(1));
    step(1'b0, 1'b1, 2'd2, 64'h8000_0000_0000_0001, 64'h1,
         64'h8000_0000_0000_0000, CC_ON ? 3'b010 : 3'b000, 1'b1, 1'b1, acc);
    step(1'b0, 1'b1, 2'd1, 64'h8000_0000_0000_0001, 64'h1,
         64'h8000_0000_0000_0001, CC_ON ? 3'b010 : 3'b000, 1'b1, 1'b1, acc);
    step(1'b0, 1'b1, 2'd3, 64'hFF, 64'h0F, 64'hF0, 3'b000, 1'b1, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, '0, '0, '0, 3'b000, 1'b1, 1'b0, acc);

    // Back-pressure: only STAGES beats fit while the consumer stalls.
    for (int i = 0; i < 6; i++) begin
      bp_op[i] = 2'($urandom_range(0, 3));
      bp_a[i]  = {$urandom(), $urandom()};
      bp_b[i]  = {$urandom(), $urandom()};
    end
    got = 0;
    for (int i = 0; i < 6; i++) begin
      r = ref_res(bp_op[got], bp_a[got], bp_b[got]);
      step(1'b0, 1'b1, bp_op[got], bp_a[got], bp_b[got], r, ref_cc(r), 1'b0, 1'b0, acc);
      if (acc) got++;
    end
    chk("bp_accepted", WIDTH'(got), WIDTH'(STAGES));
    chk("bp_full_in_ready", WIDTH'(in_ready), WIDTH'(0));
    r = ref_res(bp_op[got], bp_a[got], bp_b[got]);
    step(1'b0, 1'b1, bp_op[got], bp_a[got], bp_b[got], r, ref_cc(r), 1'b1, 1'b0, acc);
    chk("release_in_ready", WIDTH'(acc), WIDTH'(1));
    if (acc) got++;
    for (int i = 0; i < 20 && got < 6; i++) begin
      r = ref_res(bp_op[got], bp_a[got], bp_b[got]);
      step(1'b0, 1'b1, bp_op[got], bp_a[got], bp_b[got], r, ref_cc(r), 1'b1, 1'b0, acc);
      if (acc) got++;
    end
    chk("bp_all_accepted", WIDTH'(got), WIDTH'(6));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'd0, '0, '0, '0, 3'b000, 1'b1, 1'b0, acc);

    // Reset with two beats in flight: they must vanish.
    step(1'b0, 1'b1, 2'd1, 64'h1, 64'h2, 64'h3, 3'b000, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 2'd1, 64'h4, 64'h8, 64'hC, 3'b000, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 2'd0, '0, '0, '0, 3'b000, 1'b0, 1'b0, acc);
    exp_q.delete();
    step(1'b0, 1'b1, 2'd2, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F,
         64'h0FF0_0FF0_0FF0_0FF0, 3'b000, 1'b1, 1'b1, acc);
    chk("accept_after_midrst", WIDTH'(acc), WIDTH'(1));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'd0, '0, '0, '0, 3'b000, 1'b1, 1'b0, acc);
    chk("midrst_drained", WIDTH'(exp_q.size()), WIDTH'(0));

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      rnd_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
    end

    // Bounded drain.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      step(1'b0, 1'b0, 2'd0, '0, '0, '0, 3'b000, 1'b1, 1'b0, acc);
    end
    step(1'b0, 1'b0, 2'd0, '0, '0, '0, 3'b000, 1'b1, 1'b0, acc);
    chk("final_drain", WIDTH'(exp_q.size()), WIDTH'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
